// File: rtl/spi_register_controller.sv
// Frame-level SPI command interpreter: the first byte of each chip-select frame selects
// read/write and a start address, then register writes or read prefetches follow with optional auto-increment.
module spi_register_controller #(
  parameter logic [7:0]  IDLE_BYTE      = 8'hFF,
  parameter int unsigned AUTO_INCREMENT = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       FrameActive_i,
  input  logic       ByteDone_i,
  input  logic [7:0] ByteReceived_i,
  output logic [7:0] DataToSend_o,
  output logic [6:0] RegAddr_o,
  output logic [7:0] RegWriteData_o,
  output logic       RegWrite_o,
  output logic       RegRead_o,
  input  logic [7:0] RegReadData_i,
  output logic       Busy_o,
  output logic       Overrun_o
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_COMMAND     = 3'd1,
    S_WRITE       = 3'd2,
    S_READ_REQ    = 3'd3,
    S_READ_WAIT   = 3'd4,
    S_READ_STREAM = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] tx_q, tx_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic       busy_q, busy_d;
  logic       ovr_q, ovr_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      tx_q    <= IDLE_BYTE;
      addr_q  <= 7'd0;
      wdata_q <= 8'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    ovr_d   = ovr_q;

    // Write address advances the cycle after the strobe, so the strobe sees the current address.
    if (wr_q && (AUTO_INCREMENT != 0)) begin
      addr_d = addr_q + 7'd1;
    end

    if (state_q == S_IDLE) begin
      if (FrameActive_i) begin
        state_d = S_COMMAND;
        ovr_d   = 1'b0;
      end
    end else if (!FrameActive_i) begin
      state_d = S_IDLE;
      tx_d    = IDLE_BYTE;
    end else begin
      case (state_q)
        S_COMMAND: begin
          tx_d = IDLE_BYTE;
          if (ByteDone_i) begin
            addr_d  = ByteReceived_i[6:0];
            state_d = ByteReceived_i[7] ? S_READ_REQ : S_WRITE;
            rd_d    = ByteReceived_i[7];
          end
        end
        S_WRITE: begin
          tx_d = IDLE_BYTE;
          if (ByteDone_i) begin
            wr_d    = 1'b1;
            wdata_d = ByteReceived_i;
          end
        end
        S_READ_REQ: begin
          if (ByteDone_i) ovr_d = 1'b1;
          state_d = S_READ_WAIT;
        end
        S_READ_WAIT: begin
          if (ByteDone_i) ovr_d = 1'b1;
          tx_d    = RegReadData_i;
          state_d = S_READ_STREAM;
          if (AUTO_INCREMENT != 0) addr_d = addr_q + 7'd1;
        end
        S_READ_STREAM: begin
          if (ByteDone_i) begin
            state_d = S_READ_REQ;
            rd_d    = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = IDLE_BYTE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  assign DataToSend_o   = tx_q;
  assign RegAddr_o      = addr_q;
  assign RegWriteData_o = wdata_q;
  assign RegWrite_o     = wr_q;
  assign RegRead_o      = rd_q;
  assign Busy_o         = busy_q;
  assign Overrun_o      = ovr_q;

endmodule

// File: tb/tb_spi_register_controller.sv
// Scoreboard bench for spi_register_controller: directed frames push expected strobes and
// status snapshots into a queue; a negedge monitor pops and compares.
module tb_spi_register_controller;

  localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_STAT = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [6:0] addr;
    logic [7:0] data;
    logic       busy;
    logic       ovr;
    logic [7:0] tx;
    logic       full;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       FrameActive_i;
  logic       ByteDone_i;
  logic [7:0] ByteReceived_i;
  logic [7:0] DataToSend_o;
  logic [6:0] RegAddr_o;
  logic [7:0] RegWriteData_o;
  logic       RegWrite_o;
  logic       RegRead_o;
  logic [7:0] RegReadData_i;
  logic       Busy_o;
  logic       Overrun_o;

  logic [7:0] mem [128];
  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         tx_cnt = 0;
  logic [7:0] tx_exp = 8'h00;
  logic       fin_req = 1'b0;
  logic       fin_ack = 1'b0;

  spi_register_controller dut (
    .Clock(Clock), .Reset(Reset), .FrameActive_i(FrameActive_i), .ByteDone_i(ByteDone_i),
    .ByteReceived_i(ByteReceived_i), .DataToSend_o(DataToSend_o), .RegAddr_o(RegAddr_o),
    .RegWriteData_o(RegWriteData_o), .RegWrite_o(RegWrite_o), .RegRead_o(RegRead_o),
    .RegReadData_i(RegReadData_i), .Busy_o(Busy_o), .Overrun_o(Overrun_o)
  );

  always #5 Clock = ~Clock;

  // Register bank model: read data valid the cycle after the read strobe.
  always @(posedge Clock) begin
    if (RegRead_o) RegReadData_i <= mem[RegAddr_o];
  end

  always @(negedge Clock) begin
    exp_t e;
    if (tx_cnt > 0) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt == 0) begin
        n_vec++;
        if (DataToSend_o !== tx_exp) begin
          n_err++;
          $display("FAIL read_tx: got %h want %h", DataToSend_o, tx_exp);
        end
      end
    end
    while (exp_q.size() > 0 && exp_q[0].kind == K_STAT) begin
      e = exp_q.pop_front();
      n_vec++;
      if (Busy_o !== e.busy || Overrun_o !== e.ovr || DataToSend_o !== e.tx ||
          (e.full && (RegAddr_o !== e.addr || RegWriteData_o !== e.data))) begin
        n_err++;
        $display("FAIL status: got busy=%b ovr=%b tx=%h addr=%h wd=%h want busy=%b ovr=%b tx=%h addr=%h wd=%h (addr/wd checked=%b)",
                 Busy_o, Overrun_o, DataToSend_o, RegAddr_o, RegWriteData_o,
                 e.busy, e.ovr, e.tx, e.addr, e.data, e.full);
      end
    end
    if (RegWrite_o === 1'b1 && RegRead_o === 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL strobe_overlap: got both strobes high want at most one");
    end
    if (RegWrite_o === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0 || exp_q[0].kind != K_WR) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%h data=%h want no write", RegAddr_o, RegWriteData_o);
      end else begin
        e = exp_q.pop_front();
        if (RegAddr_o !== e.addr || RegWriteData_o !== e.data) begin
          n_err++;
          $display("FAIL write: got addr=%h data=%h want addr=%h data=%h",
                   RegAddr_o, RegWriteData_o, e.addr, e.data);
        end
      end
    end
    if (RegRead_o === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0 || exp_q[0].kind != K_RD) begin
        n_err++;
        $display("FAIL unexpected_read: got addr=%h want no read", RegAddr_o);
      end else begin
        e = exp_q.pop_front();
        if (RegAddr_o !== e.addr) begin
          n_err++;
          $display("FAIL read_addr: got %h want %h", RegAddr_o, e.addr);
        end
        tx_cnt = 2;
        tx_exp = e.data;
      end
    end
    if (fin_req && !fin_ack) begin
      n_vec++;
      if (exp_q.size() != 0 || tx_cnt != 0) begin
        n_err++;
        $display("FAIL leftover: got %0d expectations pending want 0", exp_q.size());
      end
      fin_ack = 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ByteDone_i = 1'b1;
    ByteReceived_i = b;
    cyc(1);
    ByteDone_i = 1'b0;
    cyc(9);
  endtask

  task automatic exp_wr(input logic [6:0] a, input logic [7:0] d);
    exp_t e;
    e = '{kind: K_WR, addr: a, data: d, busy: 1'b0, ovr: 1'b0, tx: 8'h00, full: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic exp_rd(input logic [6:0] a, input logic [7:0] d);
    exp_t e;
    e = '{kind: K_RD, addr: a, data: d, busy: 1'b0, ovr: 1'b0, tx: 8'h00, full: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic exp_stat(input logic b, input logic o, input logic [7:0] t,
                          input logic f, input logic [6:0] a, input logic [7:0] d);
    exp_t e;
    e = '{kind: K_STAT, addr: a, data: d, busy: b, ovr: o, tx: t, full: f};
    exp_q.push_back(e);
  endtask

  task automatic open_frame();
    FrameActive_i = 1'b1;
    cyc(2);
  endtask

  task automatic close_frame();
    FrameActive_i = 1'b0;
    cyc(2);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[10] = 8'h3C;
    mem[11] = 8'h4D;
    mem[12] = 8'h5E;
    mem[48] = 8'hC5;
    RegReadData_i  = 8'h00;
    Reset          = 1'b0;
    FrameActive_i  = 1'b1;
    ByteDone_i     = 1'b0;
    ByteReceived_i = 8'h05;

    // Reset held with frame active and ByteDone toggling.
    for (int i = 0; i < 6; i++) begin
      ByteDone_i = ~ByteDone_i;
      cyc(1);
    end
    exp_stat(1'b0, 1'b0, 8'hFF, 1'b1, 7'd0, 8'h00);
    cyc(1);
    ByteDone_i = 1'b0;
    FrameActive_i = 1'b0;
    Reset = 1'b1;
    cyc(2);
    exp_stat(1'b0, 1'b0, 8'hFF, 1'b1, 7'd0, 8'h00);
    cyc(1);

    // Write frame 05 A1 B2.
    open_frame();
    send(8'h05);
    exp_stat(1'b1, 1'b0, 8'hFF, 1'b0, 7'd0, 8'h00);
    exp_wr(7'd5, 8'hA1);
    send(8'hA1);
    exp_wr(7'd6, 8'hB2);
    send(8'hB2);
    exp_stat(1'b1, 1'b0, 8'hFF, 1'b1, 7'd7, 8'hB2);
    close_frame();
    exp_stat(1'b0, 1'b0, 8'hFF, 1'b0, 7'd0, 8'h00);
    cyc(1);

    // Read frame 8A 00 00.
    open_frame();
    exp_rd(7'd10, 8'h3C);
    send(8'h8A);
    exp_rd(7'd11, 8'h4D);
    send(8'h00);
    exp_rd(7'd12, 8'h5E);
    send(8'h00);
    exp_stat(1'b1, 1'b0, 8'h5E, 1'b1, 7'd13, 8'hB2);
    close_frame();
    exp_stat(1'b0, 1'b0, 8'hFF, 1'b0, 7'd0, 8'h00);
    cyc(1);

    // Address wrap 127 -> 0.
    open_frame();
    send(8'h7F);
    exp_wr(7'd127, 8'h11);
    send(8'h11);
    exp_wr(7'd0, 8'h22);
    send(8'h22);
    exp_stat(1'b1, 1'b0, 8'hFF, 1'b1, 7'd1, 8'h22);
    close_frame();

    // Frame drop coincident with a data byte: byte discarded, no write.
    open_frame();
    send(8'h03);
    ByteDone_i = 1'b1;
    ByteReceived_i = 8'h99;
    FrameActive_i = 1'b0;
    cyc(1);
    ByteDone_i = 1'b0;
    cyc(3);
    exp_stat(1'b0, 1'b0, 8'hFF, 1'b1, 7'd3, 8'h22);
    cyc(1);
    open_frame();
    send(8'h20);
    exp_wr(7'h20, 8'h77);
    send(8'h77);
    exp_stat(1'b1, 1'b0, 8'hFF, 1'b1, 7'h21, 8'h77);
    close_frame();

    // Overrun: second ByteDone one cycle after a read command.
    open_frame();
    exp_rd(7'd48, 8'hC5);
    ByteDone_i = 1'b1;
    ByteReceived_i = 8'hB0;
    cyc(1);
    ByteReceived_i = 8'h00;
    cyc(1);
    ByteDone_i = 1'b0;
    cyc(6);
    exp_stat(1'b1, 1'b1, 8'hC5, 1'b1, 7'd49, 8'h77);
    close_frame();
    exp_stat(1'b0, 1'b1, 8'hFF, 1'b0, 7'd0, 8'h00);
    cyc(1);
    FrameActive_i = 1'b1;
    cyc(1);
    exp_stat(1'b1, 1'b0, 8'hFF, 1'b0, 7'd0, 8'h00);
    cyc(1);
    close_frame();

    // Reset right after a data byte is captured: the pending strobe must never appear.
    open_frame();
    send(8'h40);
    ByteDone_i = 1'b1;
    ByteReceived_i = 8'h66;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    ByteDone_i = 1'b0;
    exp_stat(1'b0, 1'b0, 8'hFF, 1'b1, 7'd0, 8'h00);
    cyc(2);
    FrameActive_i = 1'b0;
    Reset = 1'b1;
    cyc(4);

    fin_req = 1'b1;
    repeat (5) @(posedge Clock);
    if (!fin_ack) begin
      $display("FAIL monitor_finish: got no final check want final check done");
      $fatal(1, "monitor did not complete");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
